write_channel_arbiter: RTL and testbench



---
 rtl/write_channel_arbiter_if.sv | 31 +++
 rtl/write_channel_arbiter.sv | 137 +++++++++++++
 tb/tb_write_channel_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/write_channel_arbiter_if.sv
// Requester and write-channel bundle of the write channel arbiter.
// The arbiter uses the master modport; the requesters and the channel use the slave modport.
interface write_channel_arbiter_if #(
    parameter int NUM_REQ     = 2,
    parameter int LINE_ADDR_W = 27,
    parameter int LINE_W      = 256,
    parameter int FE_NBYTES   = 4
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*LINE_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LINE_W-1:0]      req_wdata;
    logic [NUM_REQ*FE_NBYTES-1:0]   req_wstrb;
    logic [NUM_REQ-1:0]             req_ready;
    logic [NUM_REQ-1:0]             req_done;
    logic                           busy;
    logic                           wc_valid;
    logic [LINE_ADDR_W-1:0]         wc_addr;
    logic [LINE_W-1:0]              wc_wdata;
    logic [FE_NBYTES-1:0]           wc_wstrb;
    logic                           wc_ready;

    modport master (
        input  req_valid, req_addr, req_wdata, req_wstrb, wc_ready,
        output req_ready, req_done, busy, wc_valid, wc_addr, wc_wdata, wc_wstrb
    );

    modport slave (
        output req_valid, req_addr, req_wdata, req_wstrb, wc_ready,
        input  req_ready, req_done, busy, wc_valid, wc_addr, wc_wdata, wc_wstrb
    );
endinterface

// File: rtl/write_channel_arbiter.sv
// Shares one cache-line write channel among NUM_REQ writers, one transaction in flight at a time.
// Define WRITE_ARB_FIXED_PRIO_EN for fixed lowest-index priority; default is round-robin.
module write_channel_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int FE_ADDR_W  = 32,
    parameter int FE_DATA_W  = 32,
    parameter int WORD_OFF_W = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    write_channel_arbiter_if.master     bus
);
    localparam int FE_NBYTES   = FE_DATA_W / 8;
    localparam int FE_BYTE_W   = $clog2(FE_NBYTES);
    localparam int LINE_ADDR_W = FE_ADDR_W - FE_BYTE_W - WORD_OFF_W;
    localparam int LINE_W      = FE_DATA_W << WORD_OFF_W;
    localparam int OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t                 state;
    logic [OWN_W-1:0]       owner;
    logic                   wc_valid_r;
    logic [LINE_ADDR_W-1:0] wc_addr_r;
    logic [LINE_W-1:0]      wc_wdata_r;
    logic [FE_NBYTES-1:0]   wc_wstrb_r;
    logic [NUM_REQ-1:0]     done_r;

    logic                   grant_any;
    logic [OWN_W-1:0]       grant_idx;
    logic [OWN_W-1:0]       cand;
    logic [NUM_REQ-1:0]     grant;
    logic [LINE_ADDR_W-1:0] sel_addr;
    logic [LINE_W-1:0]      sel_wdata;
    logic [FE_NBYTES-1:0]   sel_wstrb;

`ifndef WRITE_ARB_FIXED_PRIO_EN
    logic [OWN_W-1:0]       rr_ptr;
`endif

    // Arbitration: scan downward so the highest-priority candidate is assigned last.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        grant     = '0;
`ifdef WRITE_ARB_FIXED_PRIO_EN
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = OWN_W'(i);
            if (bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
`else
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = OWN_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (bus.req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
`endif
        if (state == IDLE && grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == OWN_W'(i)) begin
                sel_addr  = bus.req_addr[i*LINE_ADDR_W +: LINE_ADDR_W];
                sel_wdata = bus.req_wdata[i*LINE_W +: LINE_W];
                sel_wstrb = bus.req_wstrb[i*FE_NBYTES +: FE_NBYTES];
            end
        end
    end

    // Transaction FSM; payload registers change only on an accept in IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            wc_valid_r <= 1'b0;
            wc_addr_r  <= '0;
            wc_wdata_r <= '0;
            wc_wstrb_r <= '0;
            done_r     <= '0;
`ifndef WRITE_ARB_FIXED_PRIO_EN
            rr_ptr     <= '0;
`endif
        end else begin
            done_r <= '0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_idx;
                        wc_addr_r  <= sel_addr;
                        wc_wdata_r <= sel_wdata;
                        wc_wstrb_r <= sel_wstrb;
                        wc_valid_r <= 1'b1;
                        state      <= ISSUE;
`ifndef WRITE_ARB_FIXED_PRIO_EN
                        rr_ptr     <= (grant_idx == OWN_W'(NUM_REQ - 1)) ? '0
                                                                         : grant_idx + OWN_W'(1);
`endif
                    end
                end
                ISSUE: begin
                    wc_valid_r <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (bus.wc_ready) begin
                        done_r[owner] <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: begin
                    wc_valid_r <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = grant;
    assign bus.req_done  = done_r;
    assign bus.busy      = (state != IDLE);
    assign bus.wc_valid  = wc_valid_r;
    assign bus.wc_addr   = wc_addr_r;
    assign bus.wc_wdata  = wc_wdata_r;
    assign bus.wc_wstrb  = wc_wstrb_r;
endmodule

// File: tb/tb_write_channel_arbiter.sv
// Bench for write_channel_arbiter: cycle table, hand-written corner sequences, then random traffic
// checked against a timestamp-based transaction model.
module tb_write_channel_arbiter;
    localparam int NR  = 2;
    localparam int LAW = 27;
    localparam int LW  = 256;
    localparam int NB  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    write_channel_arbiter_if #(.NUM_REQ(NR), .LINE_ADDR_W(LAW), .LINE_W(LW), .FE_NBYTES(NB)) bus ();

    write_channel_arbiter #(.NUM_REQ(NR), .FE_ADDR_W(32), .FE_DATA_W(32), .WORD_OFF_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic [LAW-1:0] ra [NR];
    logic [LW-1:0]  rd [NR];
    logic [NB-1:0]  rs [NR];
    logic [NR-1:0]  rv;

    typedef struct {
        logic       rst;
        logic [1:0] rv;
        logic       wr;
        logic [1:0] rdy;
        logic [1:0] done;
        logic       busy;
        logic       wcv;
    } vec_t;

    vec_t tbl [14];

`ifdef WRITE_ARB_FIXED_PRIO_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = rv;
        bus.req_addr  = {ra[1], ra[0]};
        bus.req_wdata = {rd[1], rd[0]};
        bus.req_wstrb = {rs[1], rs[0]};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [LW-1:0] pat;
    int            pend, acc_cyc, done_cyc, done_own, nxt, win;
    logic [LAW-1:0] m_addr;
    logic [LW-1:0]  m_data;
    logic [NB-1:0]  m_strb;
    logic [1:0]     exp_rdy, exp_done;

    initial begin
        tbl[0]  = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 2'b11, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 2'b11, 1'b0, FP ? 2'b01 : 2'b10, 2'b01, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 2'b11, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[8]  = '{1'b0, 2'b11, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 2'b11, 1'b0, 2'b01, FP ? 2'b01 : 2'b10, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0};

        for (int i = 0; i < NR; i++) begin
            ra[i] = '0;
            rd[i] = '0;
            rs[i] = '0;
        end
        rv            = '0;
        bus.wc_ready  = 1'b0;
        reset         = 1'b1;
        drive();
        repeat (3) @(posedge clk);
        #1;

        // Reset state while reset is still held
        #2;
        chk("rst.busy", bus.busy, 1'b0);
        chk("rst.wc_valid", bus.wc_valid, 1'b0);
        chk("rst.req_done", bus.req_done, 2'b00);
        chk("rst.req_ready", bus.req_ready, 2'b00);
        chk("rst.wc_addr", bus.wc_addr, '0);
        chk("rst.wc_wstrb", bus.wc_wstrb, '0);
        tick();

        // Cycle table: ready ignored in IDLE/ISSUE, arbitration order, done timing
        for (int i = 0; i < 14; i++) begin
            reset        = tbl[i].rst;
            rv           = tbl[i].rv;
            bus.wc_ready = tbl[i].wr;
            drive();
            #2;
            chk($sformatf("tbl%0d.req_ready", i), bus.req_ready, tbl[i].rdy);
            chk($sformatf("tbl%0d.req_done", i), bus.req_done, tbl[i].done);
            chk($sformatf("tbl%0d.busy", i), bus.busy, tbl[i].busy);
            chk($sformatf("tbl%0d.wc_valid", i), bus.wc_valid, tbl[i].wcv);
            tick();
        end

        // Single req0 with long wait, payload changed after accept, re-accept in done cycle
        pat   = {4{64'h0123_4567_89AB_CDEF}};
        ra[0] = 27'h0000123;
        rd[0] = pat;
        rs[0] = 4'hF;
        rv    = 2'b01;
        drive();
        #2;
        chk("seq1.accept_ready", bus.req_ready, 2'b01);
        tick();
        ra[0] = 27'h7FFFFFF;
        rd[0] = ~pat;
        rs[0] = 4'h3;
        rv    = 2'b00;
        drive();
        #2;
        chk("seq1.wc_valid", bus.wc_valid, 1'b1);
        chk("seq1.wc_addr", bus.wc_addr, 27'h0000123);
        chk("seq1.wc_wdata", bus.wc_wdata, pat);
        chk("seq1.wc_wstrb", bus.wc_wstrb, 4'hF);
        tick();
        for (int k = 0; k < 20; k++) begin
            #2;
            chk($sformatf("seq1.hold%0d.wc_valid", k), bus.wc_valid, 1'b0);
            chk($sformatf("seq1.hold%0d.wc_addr", k), bus.wc_addr, 27'h0000123);
            chk($sformatf("seq1.hold%0d.wc_wdata", k), bus.wc_wdata, pat);
            chk($sformatf("seq1.hold%0d.req_done", k), bus.req_done, 2'b00);
            tick();
        end
        bus.wc_ready = 1'b1;
        #2;
        chk("seq1.ready_cycle.req_done", bus.req_done, 2'b00);
        tick();
        bus.wc_ready = 1'b0;
        rv           = 2'b01;
        drive();
        #2;
        chk("seq6.req_done", bus.req_done, 2'b01);
        chk("seq6.req_ready", bus.req_ready, 2'b01);
        tick();
        rv = 2'b00;
        drive();
        #2;
        chk("seq6.done_cleared", bus.req_done, 2'b00);
        chk("seq6.wc_valid", bus.wc_valid, 1'b1);
        chk("seq4.wc_addr_new", bus.wc_addr, 27'h7FFFFFF);
        chk("seq4.wc_wstrb_new", bus.wc_wstrb, 4'h3);
        tick();
        #2;
        chk("seq5.pre.busy", bus.busy, 1'b1);

        // Reset in WAIT discards the transaction
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #2;
        chk("seq5.busy", bus.busy, 1'b0);
        chk("seq5.wc_valid", bus.wc_valid, 1'b0);
        chk("seq5.req_done", bus.req_done, 2'b00);
        chk("seq5.wc_addr", bus.wc_addr, '0);
        bus.wc_ready = 1'b1;
        tick();
        bus.wc_ready = 1'b0;
        #2;
        chk("seq5.late_ready.req_done", bus.req_done, 2'b00);
        chk("seq5.late_ready.busy", bus.busy, 1'b0);
        tick();

        // Random traffic against a transaction-level model
        pend     = -1;
        acc_cyc  = -10;
        done_cyc = -10;
        done_own = 0;
        nxt      = 0;
        m_addr   = '0;
        m_data   = '0;
        m_strb   = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NR; i++) begin
                ra[i] = LAW'($urandom);
                rd[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                rs[i] = NB'($urandom);
            end
            rv           = {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)};
            bus.wc_ready = ($urandom_range(0, 3) == 0);
            drive();
            #2;

            win = -1;
            if (pend < 0) begin
                for (int k = 0; k < NR; k++) begin
                    int j;
                    j = (nxt + k) % NR;
                    if (win < 0 && ((rv >> j) & 2'b01) != 2'b00) win = j;
                end
            end
            exp_rdy  = (win >= 0) ? 2'(1 << win) : 2'b00;
            exp_done = (c == done_cyc) ? 2'(1 << done_own) : 2'b00;

            chk($sformatf("rnd%0d.req_ready", c), bus.req_ready, exp_rdy);
            chk($sformatf("rnd%0d.req_done", c), bus.req_done, exp_done);
            chk($sformatf("rnd%0d.busy", c), bus.busy, pend >= 0);
            chk($sformatf("rnd%0d.wc_valid", c), bus.wc_valid, (pend >= 0) && (c == acc_cyc + 1));
            if (pend >= 0) begin
                chk($sformatf("rnd%0d.wc_addr", c), bus.wc_addr, m_addr);
                chk($sformatf("rnd%0d.wc_wdata", c), bus.wc_wdata, m_data);
                chk($sformatf("rnd%0d.wc_wstrb", c), bus.wc_wstrb, m_strb);
            end

            if (pend >= 0) begin
                if (c >= acc_cyc + 2 && bus.wc_ready) begin
                    done_cyc = c + 1;
                    done_own = pend;
                    pend     = -1;
                end
            end else if (win >= 0) begin
                pend    = win;
                acc_cyc = c;
                m_addr  = (win == 1) ? ra[1] : ra[0];
                m_data  = (win == 1) ? rd[1] : rd[0];
                m_strb  = (win == 1) ? rs[1] : rs[0];
                if (!FP) nxt = (win + 1) % NR;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
